// File: rtl/hps_bridge_pkg.sv
// hps_bridge_pkg
//   Shared definitions for the HPS-FPGA bridge responder:
//   register indices (byte offset >> 2), CTRL/STATUS bit positions and the
//   ADV7513 command word layout carried through the command FIFO.
package hps_bridge_pkg;

    // Register indices, selected by AXI_Address[4:2]
    localparam logic [2:0] REG_ID      = 3'd0;  // 0x00
    localparam logic [2:0] REG_CTRL    = 3'd1;  // 0x04
    localparam logic [2:0] REG_STATUS  = 3'd2;  // 0x08
    localparam logic [2:0] REG_CMD     = 3'd3;  // 0x0C
    localparam logic [2:0] REG_SCRATCH = 3'd4;  // 0x10

    // CTRL bit positions
    localparam int CTRL_VID_EN  = 0;
    localparam int CTRL_PAT_LSB = 1;
    localparam int CTRL_PAT_MSB = 2;

    // STATUS bit positions
    localparam int STAT_HPD      = 0;
    localparam int STAT_HPD_CHG  = 1;
    localparam int STAT_LVL_LSB  = 2;
    localparam int STAT_LVL_MSB  = 6;
    localparam int STAT_FULL     = 7;
    localparam int STAT_EMPTY    = 8;
    localparam int STAT_OVF      = 9;
    localparam int STAT_NACK_LSB = 16;
    localparam int STAT_NACK_MSB = 23;
    localparam int STAT_NACK_CLR = 31;

    // ADV7513 register write command
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_word_t;

endpackage

// File: rtl/hps_bridge_responder_cmd_fifo.sv
// cmd_fifo
//   Synchronous FIFO with occupancy level. A push while full is accepted
//   only when a pop happens in the same cycle; otherwise it is dropped and
//   o_drop pulses for that cycle. o_data reads 0 while empty.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_data   write request and data
//   i_pop_req        consumer ready; pops only when not empty
//   o_data           head entry
//   o_level          entries held, 0..DEPTH
//   o_full, o_empty  occupancy flags
//   o_drop           push discarded this cycle
module cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop_req,
    output logic [WIDTH-1:0] o_data,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_level = r_level;

    // A pop frees a slot in the same cycle, so a push while full is legal then
    assign w_pop  = i_pop_req && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    assign o_drop = i_push && o_full && !w_pop;

    // Gate the head so stale storage never shows after reset or a drain
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/hps_bridge_responder.sv
// hps_bridge_responder
//   FPGA-side responder on the HPS-FPGA bridge. Decodes reads/writes into a
//   small register bank (ID, CTRL, STATUS, CMD, SCRATCH), drives the video
//   enable/pattern controls, tracks ADV7513 hot-plug, counts I2C NACKs and
//   queues ADV7513 register-write commands for the I2C configuration master.
// Ports:
//   FPGA_CLK1_50, FPGA_RESET     clock, asynchronous active-high reset
//   AXI_Address/Read/Write/WriteData   bridge access (single-cycle strobes)
//   AXI_ReadData, AXI_ReadValid  read response, one cycle after AXI_Read
//   ADV_HPD                      asynchronous hot-plug detect
//   VID_Enable, VID_Pattern      video path controls (CTRL register)
//   CMD_Valid/Ready/Data         command FIFO head toward the I2C master
//   CMD_Nack                     NACK pulse from the I2C master
module hps_bridge_responder
    import hps_bridge_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'h4C414250,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        FPGA_CLK1_50,
    input  logic        FPGA_RESET,
    input  logic [18:0] AXI_Address,
    input  logic        AXI_Read,
    input  logic        AXI_Write,
    input  logic [31:0] AXI_WriteData,
    output logic [31:0] AXI_ReadData,
    output logic        AXI_ReadValid,
    input  logic        ADV_HPD,
    output logic        VID_Enable,
    output logic [1:0]  VID_Pattern,
    output logic        CMD_Valid,
    input  logic        CMD_Ready,
    output logic [15:0] CMD_Data,
    input  logic        CMD_Nack
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [2:0]  r_ctrl;
    logic [31:0] r_scratch;
    logic        r_hpd_meta;
    logic        r_hpd_sync;
    logic        r_hpd_prev;
    logic        r_hpd_changed;
    logic        r_overflow;
    logic [7:0]  r_nack_cnt;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_wr_cmd;
    logic        w_wr_scratch;
    logic        w_clr_hpd;
    logic        w_clr_ovf;
    logic        w_clr_nack;
    logic        w_hpd_edge;
    logic [31:0] w_status;
    logic [31:0] w_rd_mux;
    logic [LVL_W-1:0] w_level;
    logic        w_full;
    logic        w_empty;
    logic        w_drop;
    cmd_word_t   w_cmd_in;
    cmd_word_t   w_cmd_head;

    // Decode: only word-aligned offsets inside the 32-byte window respond
    assign w_hit = (AXI_Address[18:5] == 14'd0) && (AXI_Address[1:0] == 2'd0);
    assign w_idx = AXI_Address[4:2];

    // A read colliding with a write is dropped; the write still happens
    assign w_rd         = AXI_Read && !AXI_Write;
    assign w_wr_ctrl    = AXI_Write && w_hit && (w_idx == REG_CTRL);
    assign w_wr_status  = AXI_Write && w_hit && (w_idx == REG_STATUS);
    assign w_wr_cmd     = AXI_Write && w_hit && (w_idx == REG_CMD);
    assign w_wr_scratch = AXI_Write && w_hit && (w_idx == REG_SCRATCH);

    assign w_clr_hpd  = w_wr_status && AXI_WriteData[STAT_HPD_CHG];
    assign w_clr_ovf  = w_wr_status && AXI_WriteData[STAT_OVF];
    assign w_clr_nack = w_wr_status && AXI_WriteData[STAT_NACK_CLR];

    assign w_hpd_edge = r_hpd_sync ^ r_hpd_prev;
    assign w_cmd_in   = AXI_WriteData[15:0];

    cmd_fifo #(
        .WIDTH ($bits(cmd_word_t)),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_cmd_fifo (
        .i_clk     (FPGA_CLK1_50),
        .i_rst     (FPGA_RESET),
        .i_push    (w_wr_cmd),
        .i_data    (w_cmd_in),
        .i_pop_req (CMD_Ready),
        .o_data    (w_cmd_head),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_drop    (w_drop)
    );

    always_comb begin
        w_status = '0;
        w_status[STAT_HPD]                      = r_hpd_sync;
        w_status[STAT_HPD_CHG]                  = r_hpd_changed;
        w_status[STAT_LVL_MSB:STAT_LVL_LSB]     = 5'(w_level);
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_EMPTY]                    = w_empty;
        w_status[STAT_OVF]                      = r_overflow;
        w_status[STAT_NACK_MSB:STAT_NACK_LSB]   = r_nack_cnt;
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_hit) begin
            case (w_idx)
                REG_ID:      w_rd_mux = ID_VALUE;
                REG_CTRL:    w_rd_mux = {29'd0, r_ctrl};
                REG_STATUS:  w_rd_mux = w_status;
                REG_SCRATCH: w_rd_mux = r_scratch;
                default:     w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or posedge FPGA_RESET) begin
        if (FPGA_RESET) begin
            r_ctrl        <= '0;
            r_scratch     <= '0;
            r_hpd_meta    <= 1'b0;
            r_hpd_sync    <= 1'b0;
            r_hpd_prev    <= 1'b0;
            r_hpd_changed <= 1'b0;
            r_overflow    <= 1'b0;
            r_nack_cnt    <= '0;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
        end else begin
            r_hpd_meta <= ADV_HPD;
            r_hpd_sync <= r_hpd_meta;
            r_hpd_prev <= r_hpd_sync;

            if (w_wr_ctrl)    r_ctrl    <= AXI_WriteData[CTRL_PAT_MSB:CTRL_VID_EN];
            if (w_wr_scratch) r_scratch <= AXI_WriteData;

            // Sticky bits: a new event in the clearing cycle keeps the bit set
            r_hpd_changed <= (r_hpd_changed && !w_clr_hpd) || w_hpd_edge;
            r_overflow    <= (r_overflow && !w_clr_ovf) || w_drop;

            // Clear beats a coincident NACK; count saturates at 255
            if (w_clr_nack)
                r_nack_cnt <= '0;
            else if (CMD_Nack && (r_nack_cnt != 8'hFF))
                r_nack_cnt <= r_nack_cnt + 8'd1;

            // Read data is captured once and held until the next read
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rd_mux;
        end
    end

    assign AXI_ReadData  = r_rdata;
    assign AXI_ReadValid = r_rvalid;
    assign VID_Enable    = r_ctrl[CTRL_VID_EN];
    assign VID_Pattern   = r_ctrl[CTRL_PAT_MSB:CTRL_PAT_LSB];
    assign CMD_Valid     = !w_empty;
    assign CMD_Data      = w_cmd_head;

endmodule

// File: tb/tb_hps_bridge_responder.sv
// tb_hps_bridge_responder
//   Directed steps followed by a randomized phase, checked every cycle
//   against a behavioural model of the register bank, command queue,
//   hot-plug delay line and NACK counter.
module tb_hps_bridge_responder;

    logic        clk = 1'b0;
    logic        FPGA_RESET = 1'b0;
    logic [18:0] AXI_Address = '0;
    logic        AXI_Read = 1'b0;
    logic        AXI_Write = 1'b0;
    logic [31:0] AXI_WriteData = '0;
    logic [31:0] AXI_ReadData;
    logic        AXI_ReadValid;
    logic        ADV_HPD = 1'b0;
    logic        VID_Enable;
    logic [1:0]  VID_Pattern;
    logic        CMD_Valid;
    logic        CMD_Ready = 1'b0;
    logic [15:0] CMD_Data;
    logic        CMD_Nack = 1'b0;

    always #10 clk = ~clk;

    hps_bridge_responder dut (
        .FPGA_CLK1_50  (clk),
        .FPGA_RESET    (FPGA_RESET),
        .AXI_Address   (AXI_Address),
        .AXI_Read      (AXI_Read),
        .AXI_Write     (AXI_Write),
        .AXI_WriteData (AXI_WriteData),
        .AXI_ReadData  (AXI_ReadData),
        .AXI_ReadValid (AXI_ReadValid),
        .ADV_HPD       (ADV_HPD),
        .VID_Enable    (VID_Enable),
        .VID_Pattern   (VID_Pattern),
        .CMD_Valid     (CMD_Valid),
        .CMD_Ready     (CMD_Ready),
        .CMD_Data      (CMD_Data),
        .CMD_Nack      (CMD_Nack)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    localparam int DEPTH = 4;
    logic [2:0]  m_ctrl;
    logic [31:0] m_scratch;
    logic [15:0] m_q[$];
    bit          m_ovf;
    bit          m_chg;
    int          m_nack;
    bit [2:0]    hist;      // hist[i]: HPD input seen i+1 edges ago
    logic [31:0] m_rdata;
    logic [15:0] dut_pops[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input logic [18:0] a);
        return (a[18:5] == 14'd0) && (a[1:0] == 2'd0);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0]     = hist[1];          // input delayed by two clocks
        s[1]     = m_chg;
        s[6:2]   = 5'(m_q.size());
        s[7]     = (m_q.size() == DEPTH);
        s[8]     = (m_q.size() == 0);
        s[9]     = m_ovf;
        s[23:16] = 8'(m_nack);
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [18:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[4:2])
            3'd0:    return 32'h4C414250;
            3'd1:    return {29'd0, m_ctrl};
            3'd2:    return m_status();
            3'd4:    return m_scratch;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl = '0; m_scratch = '0; m_q.delete(); m_ovf = 0; m_chg = 0;
        m_nack = 0; hist = '0; m_rdata = '0;
    endtask

    // One clock: model consumes the driven inputs, DUT outputs are checked
    // 1 ns after the edge, then single-cycle strobes are released.
    task automatic cycle();
        bit          rd, wr, hit, push, wst, pop, hpd_evt, drop, nack, hpd_in;
        logic [31:0] exp_rd, d;
        logic [2:0]  idx;
        rd     = AXI_Read && !AXI_Write;
        wr     = AXI_Write;
        hit    = m_hit(AXI_Address);
        idx    = AXI_Address[4:2];
        d      = AXI_WriteData;
        exp_rd = m_read(AXI_Address);
        push   = wr && hit && (idx == 3'd3);
        wst    = wr && hit && (idx == 3'd2);
        pop    = CMD_Ready && (m_q.size() > 0);
        nack   = CMD_Nack;
        hpd_in = ADV_HPD;
        hpd_evt = (hist[1] != hist[2]);
        if (CMD_Valid && CMD_Ready) dut_pops.push_back(CMD_Data);
        @(posedge clk);
        #1;
        if (wr && hit && idx == 3'd1) m_ctrl = d[2:0];
        if (wr && hit && idx == 3'd4) m_scratch = d;
        m_chg = (m_chg && !(wst && d[1])) || hpd_evt;
        hist  = {hist[1:0], hpd_in};
        drop  = push && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(d[15:0]);
        m_ovf = (m_ovf && !(wst && d[9])) || drop;
        if (wst && d[31]) m_nack = 0;
        else if (nack && m_nack < 255) m_nack++;
        if (rd) m_rdata = exp_rd;
        chk("rvalid", {31'd0, AXI_ReadValid}, {31'd0, rd});
        chk("rdata", AXI_ReadData, m_rdata);
        chk("cmd_valid", {31'd0, CMD_Valid}, {31'd0, (m_q.size() > 0)});
        chk("cmd_data", {16'd0, CMD_Data}, (m_q.size() > 0) ? {16'd0, m_q[0]} : 32'd0);
        chk("vid", {29'd0, VID_Pattern, VID_Enable}, {29'd0, m_ctrl});
        AXI_Read = 0; AXI_Write = 0; CMD_Nack = 0;
    endtask

    task automatic wr(input logic [18:0] a, input logic [31:0] d);
        AXI_Address = a; AXI_WriteData = d; AXI_Write = 1; cycle();
    endtask

    task automatic rd(input logic [18:0] a);
        AXI_Address = a; AXI_Read = 1; cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Assert reset between edges; outputs must clear without a clock
    task automatic do_reset();
        FPGA_RESET = 1;
        #1;
        chk("rst_cmd_valid", {31'd0, CMD_Valid}, 32'd0);
        chk("rst_rvalid", {31'd0, AXI_ReadValid}, 32'd0);
        chk("rst_rdata", AXI_ReadData, 32'd0);
        chk("rst_vid", {29'd0, VID_Pattern, VID_Enable}, 32'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        FPGA_RESET = 0;
    endtask

    logic [18:0] addr_tab [10];

    initial begin
        addr_tab = '{19'h00, 19'h04, 19'h08, 19'h0C, 19'h0C, 19'h10,
                     19'h14, 19'h20, 19'h1000, 19'h06};
        m_reset();
        #3;
        ADV_HPD = 1;
        do_reset();

        // 1: reset state reads
        idle(3);
        rd(19'h00); chk("id", AXI_ReadData, 32'h4C414250);
        rd(19'h04); chk("ctrl_rst", AXI_ReadData, 32'h0);
        rd(19'h08); chk("status_rst", AXI_ReadData, 32'h0000_0103);
        idle(1);

        // 2: CTRL, SCRATCH, unmapped
        wr(19'h04, 32'h7);
        chk("vid_en", {31'd0, VID_Enable}, 32'd1);
        chk("vid_pat", {30'd0, VID_Pattern}, 32'd3);
        rd(19'h04); chk("ctrl_rb", AXI_ReadData, 32'h7);
        wr(19'h10, 32'hA5A5A5A5);
        rd(19'h10); chk("scratch_rb", AXI_ReadData, 32'hA5A5A5A5);
        rd(19'h20); chk("unmapped", AXI_ReadData, 32'h0);
        wr(19'h04, 32'hFFFF_FFF8);
        rd(19'h04); chk("ctrl_mask", AXI_ReadData, 32'h0);

        // 3: overflow and ordered drain
        CMD_Ready = 0;
        for (int i = 1; i <= 5; i++) wr(19'h0C, 32'h1200 + i);
        rd(19'h08);
        chk("ovf_level", {27'd0, AXI_ReadData[6:2]}, 32'd4);
        chk("ovf_full", {31'd0, AXI_ReadData[7]}, 32'd1);
        chk("ovf_bit", {31'd0, AXI_ReadData[9]}, 32'd1);
        chk("head_hold", {16'd0, CMD_Data}, 32'h1201);
        dut_pops.delete();
        CMD_Ready = 1;
        idle(6);
        chk("pop_count", dut_pops.size(), 32'd4);
        for (int i = 0; i < 4 && i < dut_pops.size(); i++)
            chk("pop_order", {16'd0, dut_pops[i]}, 32'h1201 + i);
        rd(19'h08); chk("drained_empty", {31'd0, AXI_ReadData[8]}, 32'd1);
        wr(19'h08, 32'h200);
        rd(19'h08); chk("ovf_clr", {31'd0, AXI_ReadData[9]}, 32'd0);

        // 4: push while full with a simultaneous pop
        CMD_Ready = 0;
        for (int i = 1; i <= 4; i++) wr(19'h0C, 32'hA000 + i);
        dut_pops.delete();
        CMD_Ready = 1;
        wr(19'h0C, 32'hBEEF);
        CMD_Ready = 0;
        rd(19'h08);
        chk("fullpop_level", {27'd0, AXI_ReadData[6:2]}, 32'd4);
        chk("fullpop_ovf", {31'd0, AXI_ReadData[9]}, 32'd0);
        CMD_Ready = 1;
        idle(6);
        chk("fullpop_count", dut_pops.size(), 32'd5);
        if (dut_pops.size() == 5) chk("beef_last", {16'd0, dut_pops[4]}, 32'hBEEF);

        // 5: hot-plug
        ADV_HPD = 0;
        idle(4);
        wr(19'h08, 32'h2);
        rd(19'h08); chk("hpd_low", {30'd0, AXI_ReadData[1:0]}, 32'd0);
        ADV_HPD = 1;
        idle(3);
        rd(19'h08); chk("hpd_rise", {30'd0, AXI_ReadData[1:0]}, 32'd3);
        ADV_HPD = 0;
        idle(2);
        wr(19'h08, 32'h2);       // lands on the synced falling edge
        rd(19'h08); chk("hpd_set_wins", {31'd0, AXI_ReadData[1]}, 32'd1);
        wr(19'h08, 32'h2);
        rd(19'h08); chk("hpd_w1c", {31'd0, AXI_ReadData[1]}, 32'd0);

        // 6: NACK saturation and clear priority
        for (int i = 0; i < 300; i++) begin
            CMD_Nack = 1; cycle();
        end
        rd(19'h08); chk("nack_sat", {24'd0, AXI_ReadData[23:16]}, 32'd255);
        CMD_Nack = 1;
        wr(19'h08, 32'h8000_0000);
        rd(19'h08); chk("nack_clr_wins", {24'd0, AXI_ReadData[23:16]}, 32'd0);

        // read colliding with a write: write lands, no response
        AXI_Read = 1;
        wr(19'h10, 32'h1234_5678);
        rd(19'h10); chk("collide_write", AXI_ReadData, 32'h1234_5678);

        // reset during a drain
        CMD_Ready = 0;
        for (int i = 0; i < 3; i++) wr(19'h0C, 32'h0300 + i);
        CMD_Ready = 1;
        cycle();
        #4;
        do_reset();
        rd(19'h04);  chk("post_rst_ctrl", AXI_ReadData, 32'h0);
        rd(19'h10);  chk("post_rst_scratch", AXI_ReadData, 32'h0);
        rd(19'h08);  chk("post_rst_status", AXI_ReadData, 32'h0000_0100);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            AXI_Address   = addr_tab[$urandom_range(0, 9)];
            AXI_WriteData = $urandom;
            if (r < 35)      AXI_Read = 1;
            else if (r < 62) AXI_Write = 1;
            else if (r < 65) begin AXI_Read = 1; AXI_Write = 1; end
            CMD_Ready = ($urandom_range(0, 2) == 0);
            CMD_Nack  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) ADV_HPD = ~ADV_HPD;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
